// File: rtl/mealy_1011_detector.sv
// Purpose : serial Mealy detector for the pattern 1-0-1-1 on din, with overlapping matches.
// Latency : 0 cycles; dout asserts combinationally while the 4th bit is on din, and the state advances on the next rising edge.
// Backpressure: none; one bit is consumed every clock and dout is never stalled.
//
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous active-low reset; 0 forces S0 at once and masks dout
//   din    in  1  serial data bit, consumed on the rising edge
//   dout   out 1  detect flag, high while state S3 ("101" seen) and din=1
module mealy_1011_detector (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    // Each state names the longest suffix of the input that is also a
    // prefix of 1011.
    typedef enum logic [1:0] {
        S0 = 2'b00,   // no useful prefix
        S1 = 2'b01,   // "1"
        S2 = 2'b10,   // "10"
        S3 = 2'b11    // "101"
    } state_t;

    state_t present_state;
    state_t next_state;
    logic   match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            present_state <= S0;
        end else begin
            present_state <= next_state;
        end
    end

    always_comb begin
        next_state = S0;
        match      = 1'b0;
        unique case (present_state)
            S0: next_state = din ? S1 : S0;
            S1: next_state = din ? S1 : S2;
            S2: next_state = din ? S3 : S0;
            S3: begin
                if (din) begin
                    // Full match; the trailing 1 starts the next candidate.
                    next_state = S1;
                    match      = 1'b1;
                end else begin
                    // "1010" still ends in "10".
                    next_state = S2;
                end
            end
            default: begin
                next_state = S0;
                match      = 1'b0;
            end
        endcase
    end

    // Gating with reset keeps dout low during reset, even while the
    // register is still being forced to S0 asynchronously.
    assign dout = match && reset;

endmodule

// File: tb/tb_mealy_1011_detector.sv
module tb_mealy_1011_detector;

    logic clk;
    logic reset;
    logic din;
    logic dout;

    mealy_1011_detector dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       dout;
        logic [1:0] st;
    } exp_t;

    exp_t sbq[$];

    int tests  = 0;
    int fails  = 0;
    int pulses = 0;

    // Reference model: up to the last four bits received since reset.
    logic [3:0] hist;
    int         hlen;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist = 4'b0000;
        hlen = 0;
    endtask

    // Called at posedge+1. Drives one bit, queues the expectation, checks dout
    // at the following negedge, then checks the state after the next edge.
    task automatic step(input logic b, input string tag);
        exp_t e;
        exp_t got;
        din  = b;
        hist = {hist[2:0], b};
        if (hlen < 4) hlen++;
        e.dout = (hlen >= 4) && (hist == 4'b1011);
        if (hlen >= 3 && hist[2:0] == 3'b101)      e.st = 2'b11;
        else if (hlen >= 2 && hist[1:0] == 2'b10)  e.st = 2'b10;
        else if (hlen >= 1 && hist[0])             e.st = 2'b01;
        else                                       e.st = 2'b00;
        sbq.push_back(e);

        @(negedge clk);
        got = sbq.pop_front();
        check({tag, " dout"}, {1'b0, dout}, {1'b0, got.dout});
        if (dut.present_state == 2'b11 && dout) pulses++;

        @(posedge clk);
        #1;
        check({tag, " state"}, dut.present_state, got.st);
    endtask

    // Ends at posedge+1 with the reset released.
    task automatic do_reset();
        reset = 1'b0;
        din   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        pulses = 0;
    endtask

    initial begin
        logic [6:0] pat;
        reset = 1'b0;
        din   = 1'b0;
        model_clear();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset state", dut.present_state, 2'b00);
        check("reset dout", {1'b0, dout}, 2'b00);
        reset = 1'b1;

        // Basic match 1011.
        pat = 7'b1011;
        for (int i = 3; i >= 0; i--) step(pat[i], "basic");
        check("basic pulses", pulses[1:0], 2'd1);

        // Stream 0101101: one pulse on bit 5, final state S3.
        do_reset();
        pat = 7'b0101101;
        for (int i = 6; i >= 0; i--) step(pat[i], "stream");
        check("stream pulses", pulses[1:0], 2'd1);
        check("stream final", dut.present_state, 2'b11);

        // Overlap 1011011: pulses on bits 4 and 7.
        do_reset();
        pat = 7'b1011011;
        for (int i = 6; i >= 0; i--) step(pat[i], "overlap");
        check("overlap pulses", pulses[1:0], 2'd2);

        // Near miss 101011: S3 then 0 returns to S2, one pulse on bit 6.
        do_reset();
        pat = 7'b101011;
        for (int i = 5; i >= 0; i--) step(pat[i], "nearmiss");
        check("nearmiss pulses", pulses[1:0], 2'd1);

        // Reset mid-pattern: 101, async reset between edges, then 1.
        do_reset();
        step(1'b1, "midrst");
        step(1'b0, "midrst");
        step(1'b1, "midrst");
        din = 1'b1;
        #1;
        check("midrst dout pre", {1'b0, dout}, 2'b01);
        #1;
        reset = 1'b0;
        #1;
        check("midrst async state", dut.present_state, 2'b00);
        check("midrst async dout", {1'b0, dout}, 2'b00);
        @(posedge clk);
        #1;
        check("midrst held state", dut.present_state, 2'b00);
        reset = 1'b1;
        model_clear();
        pulses = 0;
        step(1'b1, "midrst after");
        check("midrst pulses", pulses[1:0], 2'd0);
        check("midrst final", dut.present_state, 2'b01);

        // Random stream against the model.
        do_reset();
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
